accelerator_erase_scheduler: RTL and testbench
==============================================

ACCELERATOR_ERASE_SCHEDULER -- requirements
Module: accelerator_erase_scheduler

Interface
REQ-001 Parameter DATA_SIZE, default 64, width of every data and size word.
REQ-002 Parameter HEADS, fixed at 4, number of write heads sharing one vector-logistic erase unit; head index is 2 bits.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset; synchronous and active-high.
REQ-005 REQ  input  4  per-head erase-vector request, level; held by a head until its DONE bit pulses.
REQ-006 SIZE_W_IN  input  4*DATA_SIZE  packed per-head vector length W; head h at bits [h*DATA_SIZE +: DATA_SIZE].
REQ-007 E_IN  input  4*DATA_SIZE  packed per-head erase element e^(t;k).
REQ-008 E_IN_ENABLE  input  4  per-head element-valid strobe.
REQ-009 GRANT  output  4  one-hot owner of the erase unit; all-zero when idle.
REQ-010 E_OUT  output  DATA_SIZE  sigmoid result, broadcast to all heads.
REQ-011 E_OUT_ENABLE  output  4  per-head result-valid strobe; only the granted bit may be high.
REQ-012 DONE  output  4  one-cycle per-head completion pulse.
REQ-013 ERROR  output  1  one-cycle pulse on protocol violation (REQ-027).
REQ-014 LOG_START, LOG_E_IN_ENABLE  output  1 each; LOG_SIZE_W, LOG_E_IN  output  DATA_SIZE each: drive erase unit.
REQ-015 LOG_READY, LOG_E_OUT_ENABLE  input  1 each; LOG_E_OUT  input  DATA_SIZE: returned by erase unit.

Function
REQ-016 FSM states: IDLE, START, RUN, FINISH.
REQ-017 IDLE: when any REQ bit high, select winner by round-robin beginning at pointer PTR (search PTR, PTR+1, ... mod 4); register GRANT one-hot, latch winner index and its SIZE_W_IN; next state START. GRANT visible the cycle after REQ sampled.
REQ-018 IDLE with latched W = 0: skip unit, next state FINISH directly; LOG_START never asserted.
REQ-019 START: LOG_START high exactly one cycle, LOG_SIZE_W = latched W; clear in-count and out-count; next state RUN.
REQ-020 RUN: LOG_E_IN = E_IN slice of granted head, LOG_E_IN_ENABLE = E_IN_ENABLE[granted] while in-count < W; combinational pass-through, zero added latency.
REQ-021 RUN: enables beyond W elements (in-count = W) are dropped, not forwarded, and pulse ERROR.
REQ-022 RUN: E_OUT = LOG_E_OUT, E_OUT_ENABLE[granted] = LOG_E_OUT_ENABLE; out-count increments per result.
REQ-023 RUN -> FINISH when LOG_READY high and out-count (including same-cycle result) = W.
REQ-024 FINISH: DONE[granted] high one cycle, GRANT cleared, PTR = granted+1 mod 4; next state IDLE. Same head may be re-granted no earlier than two cycles after its DONE, and only if no other head requests.
REQ-025 Non-granted heads' E_IN_ENABLE ignored at all times; their E_OUT_ENABLE bits stay 0.
REQ-026 Counters DATA_SIZE wide; no wrap (counts bounded by W).
REQ-027 LOG_READY high in RUN with out-count < W: ERROR pulse, go to FINISH (head released, DONE still pulsed).
REQ-028 REQ of granted head dropping mid-service: ignored; service completes to W.
REQ-029 LOG_START, LOG_E_IN_ENABLE, E_OUT_ENABLE, DONE, ERROR never high in IDLE.

Reset
REQ-030 RST high at any edge, including mid-RUN: state IDLE, PTR = 0, counters 0, GRANT = 0, DONE = 0, ERROR = 0, LOG_START = 0, LOG_E_IN_ENABLE = 0, E_OUT_ENABLE = 0, E_OUT = 0, LOG_E_IN = 0, LOG_SIZE_W = 0.
REQ-031 Erase unit is reset by the same RST; no partial-vector results forwarded after reset.

Verification
REQ-032 Single head: REQ=0001, W=3, three inputs, unit returns three results then READY -> GRANT=0001 one cycle after REQ, one LOG_START, E_OUT_ENABLE=0001 x3, DONE=0001 one cycle.
REQ-033 Contention: REQ=1111 held, each W=2 -> grants in order 0001, 0010, 0100, 1000, 0001; no overlap; four DONE pulses.
REQ-034 W=0 on head 2 -> GRANT=0100, no LOG_START, DONE=0100 within 3 cycles.
REQ-035 Head 0 supplies 4 enables with W=3 -> 3 forwarded, 1 ERROR pulse, completion normal.
REQ-036 Unit READY after 1 of 3 results -> ERROR pulse, DONE pulse, GRANT cleared, next requester served.
REQ-037 RST mid-RUN (out-count=1) -> all outputs 0 next cycle; subsequent REQ=0010 granted from PTR=0 normally.

Source files
------------

// File: rtl/accelerator_erase_scheduler_if.sv
// Head-side and erase-unit-side signals of the erase scheduler.
// The scheduler sits on the slave modport; heads and the erase unit sit on the master modport.
interface accelerator_erase_scheduler_if #(
    parameter int DATA_SIZE = 64
);
    logic [3:0]             req;
    logic [4*DATA_SIZE-1:0] size_w_in;
    logic [4*DATA_SIZE-1:0] e_in;
    logic [3:0]             e_in_enable;
    logic [3:0]             grant;
    logic [DATA_SIZE-1:0]   e_out;
    logic [3:0]             e_out_enable;
    logic [3:0]             done;
    logic                   error;

    logic                   log_start;
    logic                   log_e_in_enable;
    logic [DATA_SIZE-1:0]   log_size_w;
    logic [DATA_SIZE-1:0]   log_e_in;
    logic                   log_ready;
    logic                   log_e_out_enable;
    logic [DATA_SIZE-1:0]   log_e_out;

    modport slave (
        input  req, size_w_in, e_in, e_in_enable,
        input  log_ready, log_e_out_enable, log_e_out,
        output grant, e_out, e_out_enable, done, error,
        output log_start, log_e_in_enable, log_size_w, log_e_in
    );

    modport master (
        output req, size_w_in, e_in, e_in_enable,
        output log_ready, log_e_out_enable, log_e_out,
        input  grant, e_out, e_out_enable, done, error,
        input  log_start, log_e_in_enable, log_size_w, log_e_in
    );
endinterface

// File: rtl/accelerator_erase_scheduler.sv
// Round-robin arbiter that time-shares one vector-logistic erase unit among four write heads.
//
// state  | meaning
// IDLE   | no owner; pick next requester round-robin from ptr
// START  | one-cycle LOG_START pulse carrying the latched vector length
// RUN    | stream granted head's elements in, results out; count both
// FINISH | DONE pulse to owner, release grant, advance ptr
module accelerator_erase_scheduler #(
    parameter int DATA_SIZE = 64,
    parameter int HEADS     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    accelerator_erase_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, START, RUN, FINISH} state_t;

    state_t               state;
    logic [1:0]           ptr;
    logic [1:0]           idx;
    logic [DATA_SIZE-1:0] w;
    logic [DATA_SIZE-1:0] in_cnt;
    logic [DATA_SIZE-1:0] out_cnt;
    logic [3:0]           grant_q;
    logic [3:0]           done_q;
    logic                 error_q;
    logic                 log_start_q;

    logic                 pick_valid;
    logic [1:0]           pick;
    logic [1:0]           cand;
    logic [DATA_SIZE-1:0] pick_size;

    logic                 in_run;
    logic [DATA_SIZE-1:0] head_e_in;
    logic                 head_en;
    logic                 in_room;
    logic                 fwd;
    logic                 overflow;
    logic                 res;
    logic                 res_cnt;
    logic [DATA_SIZE-1:0] out_total;

    // Walk offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick       = ptr;
        cand       = ptr;
        for (int i = HEADS - 1; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (bus.req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    assign pick_size = bus.size_w_in[int'(pick)*DATA_SIZE +: DATA_SIZE];

    assign in_run    = (state == RUN);
    assign head_e_in = bus.e_in[int'(idx)*DATA_SIZE +: DATA_SIZE];
    assign head_en   = bus.e_in_enable[idx];
    assign in_room   = (in_cnt < w);
    assign fwd       = in_run & head_en & in_room;
    assign overflow  = in_run & head_en & ~in_room;
    assign res       = in_run & bus.log_e_out_enable;
    assign res_cnt   = res & (out_cnt < w);
    assign out_total = out_cnt + {{(DATA_SIZE-1){1'b0}}, res_cnt};

    assign bus.log_e_in        = in_run ? head_e_in : '0;
    assign bus.log_e_in_enable = fwd;
    assign bus.e_out           = in_run ? bus.log_e_out : '0;
    assign bus.e_out_enable    = res ? grant_q : 4'b0000;
    assign bus.grant           = grant_q;
    assign bus.done            = done_q;
    assign bus.error           = error_q;
    assign bus.log_start       = log_start_q;
    assign bus.log_size_w      = w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            idx         <= 2'd0;
            w           <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            grant_q     <= 4'b0000;
            done_q      <= 4'b0000;
            error_q     <= 1'b0;
            log_start_q <= 1'b0;
        end else begin
            log_start_q <= 1'b0;
            error_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q <= 4'(1) << pick;
                        idx     <= pick;
                        w       <= pick_size;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        // Zero-length vectors never touch the erase unit.
                        if (pick_size == '0) begin
                            done_q <= 4'(1) << pick;
                            state  <= FINISH;
                        end else begin
                            log_start_q <= 1'b1;
                            state       <= START;
                        end
                    end
                end
                START: begin
                    in_cnt  <= '0;
                    out_cnt <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    if (fwd)      in_cnt  <= in_cnt + 1'b1;
                    if (res_cnt)  out_cnt <= out_total;
                    if (overflow) error_q <= 1'b1;
                    if (bus.log_ready) begin
                        done_q <= grant_q;
                        state  <= FINISH;
                        // Early READY still releases the head, but is flagged.
                        if (out_total != w) error_q <= 1'b1;
                    end
                end
                FINISH: begin
                    done_q  <= 4'b0000;
                    grant_q <= 4'b0000;
                    ptr     <= idx + 2'd1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_accelerator_erase_scheduler.sv
// Directed bench for the erase scheduler: heads and erase unit are driven from the bench.
module tb_accelerator_erase_scheduler;
    localparam int DS = 64;

    logic clk;
    logic rst;

    accelerator_erase_scheduler_if #(.DATA_SIZE(DS)) ifc ();

    accelerator_erase_scheduler #(.DATA_SIZE(DS), .HEADS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int n_start   = 0;
    int n_err     = 0;
    int n_done    = 0;
    int n_overlap = 0;
    logic [3:0] last_grant = 4'b0000;
    logic [3:0] gq[$];

    // Pulse counters on registered outputs, sampled mid-cycle.
    always @(negedge clk) begin
        if (ifc.log_start === 1'b1) n_start++;
        if (ifc.error === 1'b1) n_err++;
        if (ifc.done !== 4'b0000 && !$isunknown(ifc.done)) n_done++;
        if (!$isunknown(ifc.grant) && $countones(ifc.grant) > 1) n_overlap++;
        if (!$isunknown(ifc.grant) && ifc.grant != 4'b0000 && last_grant == 4'b0000)
            gq.push_back(ifc.grant);
        last_grant = $isunknown(ifc.grant) ? 4'b0000 : ifc.grant;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] en, input logic lo_en,
                         input logic lo_rdy, input logic [63:0] ein, input logic [63:0] lout,
                         input logic rv = 1'b0);
        @(negedge clk);
        rst                  = rv;
        ifc.req              = r;
        ifc.e_in_enable      = en;
        ifc.log_e_out_enable = lo_en;
        ifc.log_ready        = lo_rdy;
        ifc.e_in             = {ein + 64'd3, ein + 64'd2, ein + 64'd1, ein};
        ifc.log_e_out        = lout;
        #1;
    endtask

    task automatic do_reset(input string tag);
        drive(4'h0, 4'h0, 1'b1, 1'b0, 64'h0, 64'hFF, 1'b1);
        drive(4'h0, 4'h0, 1'b1, 1'b0, 64'h0, 64'hFF, 1'b1);
        check_val({tag, "_grant"}, ifc.grant, 4'h0);
        check_val({tag, "_done"}, ifc.done, 4'h0);
        check_val({tag, "_error"}, ifc.error, 1'b0);
        check_val({tag, "_log_start"}, ifc.log_start, 1'b0);
        check_val({tag, "_e_out"}, ifc.e_out, 64'h0);
        check_val({tag, "_e_out_en"}, ifc.e_out_enable, 4'h0);
        check_val({tag, "_size_w"}, ifc.log_size_w, 64'h0);
    endtask

    // Autonomous heads (W=2 each, REQ all held) and a one-cycle-latency erase unit.
    logic        pend;
    int          rcv, sent;
    logic [63:0] usize;

    task automatic auto_cycle();
        @(negedge clk);
        rst                  = 1'b0;
        ifc.req              = 4'hF;
        ifc.log_e_out_enable = pend;
        ifc.log_e_out        = 64'h1234 + 64'(rcv);
        if (pend) rcv++;
        ifc.log_ready        = pend && (64'(rcv) == usize);
        if (ifc.log_start) begin
            usize = ifc.log_size_w;
            rcv   = 0;
        end
        if (ifc.grant == 4'h0) sent = 0;
        ifc.e_in_enable = (sent < 2) ? ifc.grant : 4'h0;
        ifc.e_in        = {4{64'h5A5A}};
        #1;
        pend = ifc.log_e_in_enable;
        if (ifc.log_e_in_enable) sent++;
    endtask

    int b_start, b_err, b_done, qb, guard;
    logic [3:0] exp_g [5];

    initial begin
        rst = 1'b1;
        ifc.req = 4'h0; ifc.size_w_in = '0; ifc.e_in = '0; ifc.e_in_enable = 4'h0;
        ifc.log_ready = 1'b0; ifc.log_e_out_enable = 1'b0; ifc.log_e_out = '0;
        pend = 1'b0; rcv = 0; sent = 0; usize = '0;

        // Single head, W=3, non-granted enables ignored
        do_reset("rst0");
        ifc.size_w_in = {64'd9, 64'd9, 64'd9, 64'd3};
        b_start = n_start; b_err = n_err; b_done = n_done;
        drive(4'h1, 4'h0, 0, 0, 64'h0, 64'h0);
        check_val("t1_grant_c0", ifc.grant, 4'h0);
        drive(4'h1, 4'h0, 0, 0, 64'h0, 64'h0);
        check_val("t1_grant_c1", ifc.grant, 4'h1);
        check_val("t1_start_c1", ifc.log_start, 1'b1);
        check_val("t1_size_c1", ifc.log_size_w, 64'd3);
        check_val("t1_lei_c1", ifc.log_e_in_enable, 1'b0);
        drive(4'h1, 4'b1011, 0, 0, 64'hA0, 64'h0);
        check_val("t1_start_c2", ifc.log_start, 1'b0);
        check_val("t1_lei_c2", ifc.log_e_in_enable, 1'b1);
        check_val("t1_le_in_c2", ifc.log_e_in, 64'hA0);
        check_val("t1_eoe_c2", ifc.e_out_enable, 4'h0);
        drive(4'h1, 4'h1, 1, 0, 64'hB0, 64'h51);
        check_val("t1_le_in_c3", ifc.log_e_in, 64'hB0);
        check_val("t1_eoe_c3", ifc.e_out_enable, 4'h1);
        check_val("t1_e_out_c3", ifc.e_out, 64'h51);
        drive(4'h1, 4'h1, 1, 0, 64'hC0, 64'h52);
        check_val("t1_lei_c4", ifc.log_e_in_enable, 1'b1);
        check_val("t1_eoe_c4", ifc.e_out_enable, 4'h1);
        drive(4'h1, 4'h2, 1, 1, 64'h0, 64'h53);
        check_val("t1_lei_c5", ifc.log_e_in_enable, 1'b0);
        check_val("t1_eoe_c5", ifc.e_out_enable, 4'h1);
        check_val("t1_done_c5", ifc.done, 4'h0);
        drive(4'h0, 4'h0, 0, 0, 64'h0, 64'h0);
        check_val("t1_done_c6", ifc.done, 4'h1);
        check_val("t1_err_c6", ifc.error, 1'b0);
        drive(4'h0, 4'h0, 0, 0, 64'h0, 64'h0);
        check_val("t1_done_c7", ifc.done, 4'h0);
        check_val("t1_grant_c7", ifc.grant, 4'h0);
        check_val("t1_nstart", 64'(n_start - b_start), 64'd1);
        check_val("t1_nerr", 64'(n_err - b_err), 64'd0);
        check_val("t1_ndone", 64'(n_done - b_done), 64'd1);

        // Contention: all four heads, W=2 each
        do_reset("rst1");
        ifc.size_w_in = {64'd2, 64'd2, 64'd2, 64'd2};
        b_done = n_done; b_err = n_err;
        qb = gq.size(); guard = 0;
        pend = 1'b0; rcv = 0; sent = 0; usize = '0;
        exp_g = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        while (gq.size() < qb + 5 && guard < 100) begin
            auto_cycle();
            guard++;
        end
        check_val("t2_timeout", 64'(guard < 100), 64'd1);
        for (int i = 0; i < 5; i++)
            check_val($sformatf("t2_grant%0d", i),
                      (gq.size() > qb + i) ? 64'(gq[qb + i]) : 64'hDEAD, 64'(exp_g[i]));
        check_val("t2_ndone", 64'(n_done - b_done), 64'd4);
        check_val("t2_overlap", 64'(n_overlap), 64'd0);
        check_val("t2_nerr", 64'(n_err - b_err), 64'd0);

        // W=0 on head 2
        do_reset("rst2");
        ifc.size_w_in = {64'd5, 64'd0, 64'd5, 64'd5};
        b_start = n_start;
        drive(4'h4, 4'h0, 0, 0, 64'h0, 64'h0);
        check_val("t3_grant_c0", ifc.grant, 4'h0);
        drive(4'h4, 4'h0, 0, 0, 64'h0, 64'h0);
        check_val("t3_grant_c1", ifc.grant, 4'h4);
        check_val("t3_done_c1", ifc.done, 4'h4);
        drive(4'h0, 4'h0, 0, 0, 64'h0, 64'h0);
        check_val("t3_grant_c2", ifc.grant, 4'h0);
        check_val("t3_done_c2", ifc.done, 4'h0);
        check_val("t3_nstart", 64'(n_start - b_start), 64'd0);

        // Overflow: four enables with W=3
        do_reset("rst3");
        ifc.size_w_in = {64'd9, 64'd9, 64'd9, 64'd3};
        b_err = n_err;
        drive(4'h1, 4'h0, 0, 0, 64'h0, 64'h0);
        drive(4'h1, 4'h0, 0, 0, 64'h0, 64'h0);
        drive(4'h1, 4'h1, 0, 0, 64'hA0, 64'h0);
        check_val("t4_lei_1", ifc.log_e_in_enable, 1'b1);
        drive(4'h1, 4'h1, 1, 0, 64'hA1, 64'h61);
        check_val("t4_lei_2", ifc.log_e_in_enable, 1'b1);
        drive(4'h1, 4'h1, 1, 0, 64'hA2, 64'h62);
        check_val("t4_lei_3", ifc.log_e_in_enable, 1'b1);
        drive(4'h1, 4'h1, 1, 0, 64'hA3, 64'h63);
        check_val("t4_lei_4_dropped", ifc.log_e_in_enable, 1'b0);
        check_val("t4_eoe_3", ifc.e_out_enable, 4'h1);
        drive(4'h1, 4'h0, 0, 1, 64'h0, 64'h0);
        check_val("t4_err_pulse", ifc.error, 1'b1);
        check_val("t4_done_early", ifc.done, 4'h0);
        drive(4'h0, 4'h0, 0, 0, 64'h0, 64'h0);
        check_val("t4_done", ifc.done, 4'h1);
        check_val("t4_err_clear", ifc.error, 1'b0);
        drive(4'h0, 4'h0, 0, 0, 64'h0, 64'h0);
        check_val("t4_nerr", 64'(n_err - b_err), 64'd1);

        // Early READY, then next requester, then reset mid-RUN
        do_reset("rst4");
        ifc.size_w_in = {64'd9, 64'd9, 64'd2, 64'd3};
        drive(4'h3, 4'h0, 0, 0, 64'h0, 64'h0);
        drive(4'h3, 4'h0, 0, 0, 64'h0, 64'h0);
        check_val("t5_grant_h0", ifc.grant, 4'h1);
        drive(4'h3, 4'h1, 0, 0, 64'hA0, 64'h0);
        drive(4'h3, 4'h1, 1, 0, 64'hA1, 64'h71);
        drive(4'h3, 4'h0, 0, 1, 64'h0, 64'h0);
        check_val("t5_err_before", ifc.error, 1'b0);
        drive(4'h2, 4'h0, 0, 0, 64'h0, 64'h0);
        check_val("t5_err", ifc.error, 1'b1);
        check_val("t5_done", ifc.done, 4'h1);
        drive(4'h2, 4'h0, 0, 0, 64'h0, 64'h0);
        check_val("t5_grant_rel", ifc.grant, 4'h0);
        check_val("t5_err_clear", ifc.error, 1'b0);
        drive(4'h2, 4'h0, 0, 0, 64'h0, 64'h0);
        check_val("t5_grant_h1", ifc.grant, 4'h2);
        check_val("t5_start_h1", ifc.log_start, 1'b1);
        check_val("t5_size_h1", ifc.log_size_w, 64'd2);
        drive(4'h2, 4'h2, 0, 0, 64'hD0, 64'h0);
        check_val("t5_lei_h1", ifc.log_e_in_enable, 1'b1);
        check_val("t5_le_in_h1", ifc.log_e_in, 64'hD1);
        drive(4'h2, 4'h0, 1, 0, 64'h0, 64'h81);
        check_val("t5_eoe_h1", ifc.e_out_enable, 4'h2);
        drive(4'h2, 4'h0, 1, 0, 64'h0, 64'h77, 1'b1);
        drive(4'h3, 4'h3, 1, 0, 64'hE0, 64'h88);
        check_val("t6_grant", ifc.grant, 4'h0);
        check_val("t6_eoe", ifc.e_out_enable, 4'h0);
        check_val("t6_e_out", ifc.e_out, 64'h0);
        check_val("t6_lei", ifc.log_e_in_enable, 1'b0);
        check_val("t6_le_in", ifc.log_e_in, 64'h0);
        check_val("t6_size", ifc.log_size_w, 64'h0);
        check_val("t6_done", ifc.done, 4'h0);
        check_val("t6_err", ifc.error, 1'b0);
        drive(4'h3, 4'h0, 0, 0, 64'h0, 64'h0);
        check_val("t6_grant_ptr0", ifc.grant, 4'h1);
        check_val("t6_start", ifc.log_start, 1'b1);
        do_reset("rst5");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
